// File: rtl/axi_bank_delay.sv
// -----------------------------------------------------------------------------
// axi_bank_delay
//
// Multi-bank DRAM latency model placed on an AXI channel. A request seen in
// IDLE is classified against the bank table (row hit, closed bank, or row
// conflict). A matching countdown is loaded, and the valid/ready pair is
// released once the countdown expires. Open pages close after a run of idle
// cycles. A free-running refresh timer periodically forces a refresh window,
// and the refresh window closes every bank.
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   in_valid      upstream valid
//   in_ready      downstream ready
//   in_addr       request address, sampled while IDLE
//   out_valid     gated valid (in_valid while ACTIVE, else 0)
//   out_ready     gated ready (in_ready while ACTIVE, else 0)
//   hit_cnt       saturating count of row-hit requests
//   empty_cnt     saturating count of closed-bank requests
//   conflict_cnt  saturating count of row-conflict requests
//   refresh_busy  registered, high while in REFRESH
//
// state     | meaning
// ----------+----------------------------------------------------------------
// IDLE      | waiting for a request or a pending refresh
// COUNTDOWN | access latency running down from the loaded delay
// ACTIVE    | channel passes valid/ready through until a handshake
// REFRESH   | refresh window; all banks closed, requests held off
// -----------------------------------------------------------------------------
module axi_bank_delay #(
  parameter int ADDR_WIDTH        = 16,
  parameter int PAGE_OFFSET_WIDTH = 6,
  parameter int BANK_WIDTH        = 2,
  parameter int DELAY_WIDTH       = 5,
  parameter int HIT_DELAY         = 3,
  parameter int EMPTY_DELAY       = 7,
  parameter int CONFLICT_DELAY    = 15,
  parameter int CLOSE_TIMEOUT     = 64,
  parameter int REFRESH_PERIOD    = 512,
  parameter int REFRESH_CYCLES    = 20,
  parameter int STAT_WIDTH        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  output logic                  out_ready,
  output logic [STAT_WIDTH-1:0] hit_cnt,
  output logic [STAT_WIDTH-1:0] empty_cnt,
  output logic [STAT_WIDTH-1:0] conflict_cnt,
  output logic                  refresh_busy
);

  localparam int NUM_BANKS = 1 << BANK_WIDTH;
  localparam int ROW_WIDTH = ADDR_WIDTH - PAGE_OFFSET_WIDTH - BANK_WIDTH;

  // Each timer only needs to hold 0 .. limit-1: it clears on reaching its limit.
  localparam int IDLE_W = (CLOSE_TIMEOUT > 1) ? $clog2(CLOSE_TIMEOUT) : 1;
  localparam int RT_W   = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int BUSY_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [IDLE_W-1:0]      IDLE_LAST  = IDLE_W'(CLOSE_TIMEOUT - 1);
  localparam logic [RT_W-1:0]        RT_LAST    = RT_W'(REFRESH_PERIOD - 1);
  localparam logic [BUSY_W-1:0]      BUSY_LAST  = BUSY_W'(REFRESH_CYCLES - 1);
  localparam logic [DELAY_WIDTH-1:0] HIT_D      = DELAY_WIDTH'(HIT_DELAY);
  localparam logic [DELAY_WIDTH-1:0] EMPTY_D    = DELAY_WIDTH'(EMPTY_DELAY);
  localparam logic [DELAY_WIDTH-1:0] CONFLICT_D = DELAY_WIDTH'(CONFLICT_DELAY);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COUNT   = 2'd1;
  localparam logic [1:0] S_ACTIVE  = 2'd2;
  localparam logic [1:0] S_REFRESH = 2'd3;

  logic [1:0]             state;
  logic [DELAY_WIDTH-1:0] count;
  logic [BUSY_W-1:0]      busy_cnt;
  logic [NUM_BANKS-1:0]   bank_open;
  logic [ROW_WIDTH-1:0]   bank_row [NUM_BANKS];
  logic [IDLE_W-1:0]      idle_cnt;
  logic [RT_W-1:0]        refresh_timer;
  logic                   refresh_pending;

  logic [BANK_WIDTH-1:0]  req_bank;
  logic [ROW_WIDTH-1:0]   req_row;
  logic                   row_match;
  logic                   is_hit;
  logic                   is_conflict;
  logic                   is_empty;
  logic                   start_refresh;
  logic                   accept;
  logic                   idle_tick;
  logic                   idle_expire;
  logic                   refresh_wrap;
  logic [DELAY_WIDTH-1:0] load_delay;

  // Column bits select a word inside the page and never affect latency.
  logic unused_col;
  assign unused_col = ^in_addr[PAGE_OFFSET_WIDTH-1:0];

  assign req_bank = in_addr[PAGE_OFFSET_WIDTH +: BANK_WIDTH];
  assign req_row  = in_addr[ADDR_WIDTH-1 -: ROW_WIDTH];

  assign row_match   = (bank_row[req_bank] == req_row);
  assign is_hit      = bank_open[req_bank] & row_match;
  assign is_conflict = bank_open[req_bank] & ~row_match;
  assign is_empty    = ~bank_open[req_bank];

  // A pending refresh has priority over a request arriving in the same cycle.
  assign start_refresh = (state == S_IDLE) & refresh_pending;
  assign accept        = (state == S_IDLE) & ~refresh_pending & in_valid;

  // The idle run only advances while in_valid is low. A request therefore
  // always classifies against the table as it stood before any close.
  assign idle_tick    = (state == S_IDLE) & ~in_valid;
  assign idle_expire  = (CLOSE_TIMEOUT != 0) & idle_tick & (idle_cnt == IDLE_LAST);
  assign refresh_wrap = (REFRESH_PERIOD != 0) & (refresh_timer == RT_LAST);

  always_comb begin
    load_delay = EMPTY_D;
    if (is_hit) begin
      load_delay = HIT_D;
    end else if (is_conflict) begin
      load_delay = CONFLICT_D;
    end
  end

  assign out_valid = (state == S_ACTIVE) & in_valid;
  assign out_ready = (state == S_ACTIVE) & in_ready;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Sequencing FSM and bank table
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= '0;
      busy_cnt     <= '0;
      refresh_busy <= 1'b0;
      bank_open    <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_row[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start_refresh) begin
            state        <= S_REFRESH;
            busy_cnt     <= BUSY_LAST;
            refresh_busy <= 1'b1;
            bank_open    <= '0;
          end else if (accept) begin
            state               <= S_COUNT;
            count               <= load_delay;
            bank_open[req_bank] <= 1'b1;
            bank_row[req_bank]  <= req_row;
          end else if (idle_expire) begin
            bank_open <= '0;
          end
        end
        // A refresh that becomes pending here waits until the next IDLE.
        S_COUNT: begin
          if (count == '0) begin
            state <= S_ACTIVE;
          end else begin
            count <= count - 1'b1;
          end
        end
        S_ACTIVE: begin
          if (in_valid & in_ready) begin
            state <= S_IDLE;
          end
        end
        S_REFRESH: begin
          if (busy_cnt == '0) begin
            state        <= S_IDLE;
            refresh_busy <= 1'b0;
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Idle-close and refresh timers
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt        <= '0;
      refresh_timer   <= '0;
      refresh_pending <= 1'b0;
    end else begin
      if (idle_tick && (CLOSE_TIMEOUT != 0)) begin
        idle_cnt <= idle_expire ? '0 : idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end

      if (REFRESH_PERIOD != 0) begin
        refresh_timer <= refresh_wrap ? '0 : refresh_timer + 1'b1;
      end

      // Single flag: extra wraps before service collapse into one refresh.
      // A wrap on the service edge itself starts a fresh request.
      if (refresh_wrap) begin
        refresh_pending <= 1'b1;
      end else if (start_refresh) begin
        refresh_pending <= 1'b0;
      end
    end
  end

  // Request statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt      <= '0;
      empty_cnt    <= '0;
      conflict_cnt <= '0;
    end else if (accept) begin
      if (is_hit) begin
        hit_cnt <= sat_inc(hit_cnt);
      end
      if (is_empty) begin
        empty_cnt <= sat_inc(empty_cnt);
      end
      if (is_conflict) begin
        conflict_cnt <= sat_inc(conflict_cnt);
      end
    end
  end

endmodule

// File: tb/tb_axi_bank_delay.sv
// -----------------------------------------------------------------------------
// tb_axi_bank_delay
//
// Three instances share one clock:
//   dut  - refresh disabled; exact request model for classification, latency,
//          idle close, backpressure and reset behaviour.
//   dut3 - same inputs as dut, 2-bit statistics to exercise saturation.
//   dut2 - REFRESH_PERIOD = 40 with its own inputs/reset for refresh scenarios.
// -----------------------------------------------------------------------------
module tb_axi_bank_delay;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic        refresh_busy;
  logic [31:0] hit_cnt;
  logic [31:0] empty_cnt;
  logic [31:0] conflict_cnt;

  logic        out_valid3;
  logic        out_ready3;
  logic        refresh_busy3;
  logic [1:0]  hit3;
  logic [1:0]  empty3;
  logic [1:0]  conf3;

  logic        rst2;
  logic        in_valid2;
  logic        in_ready2;
  logic [15:0] in_addr2;
  logic        out_valid2;
  logic        out_ready2;
  logic        refresh_busy2;
  logic [31:0] hit2;
  logic [31:0] empty2;
  logic [31:0] conf2;

  int passed;
  int total;

  // Reference model: per-bank open flag and row, plus request tallies.
  bit m_open [4];
  int m_row  [4];
  int m_hit;
  int m_empty;
  int m_conf;

  axi_bank_delay #(.REFRESH_PERIOD(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .hit_cnt(hit_cnt), .empty_cnt(empty_cnt),
    .conflict_cnt(conflict_cnt), .refresh_busy(refresh_busy)
  );

  axi_bank_delay #(.REFRESH_PERIOD(0), .STAT_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .out_valid(out_valid3), .out_ready(out_ready3), .hit_cnt(hit3), .empty_cnt(empty3),
    .conflict_cnt(conf3), .refresh_busy(refresh_busy3)
  );

  axi_bank_delay #(.REFRESH_PERIOD(40)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .in_addr(in_addr2),
    .out_valid(out_valid2), .out_ready(out_ready2), .hit_cnt(hit2), .empty_cnt(empty2),
    .conflict_cnt(conf2), .refresh_busy(refresh_busy2)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_open[i] = 0;
      m_row[i]  = 0;
    end
    m_hit   = 0;
    m_empty = 0;
    m_conf  = 0;
  endtask

  // One request on dut/dut3: 'gap' idle cycles, then in_valid with addr;
  // in_ready held low for 'hold' ACTIVE cycles before the handshake.
  // Entered and left just after a rising edge with the DUT in IDLE.
  task automatic run_request(input logic [15:0] addr, input int gap, input int hold,
                             input string tag);
    int b, r, d, k, seen, bad, e;
    in_valid = 0;
    in_ready = 0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    if (gap >= 64) begin
      for (int i = 0; i < 4; i++) m_open[i] = 0;
    end
    b = int'(addr[7:6]);
    r = int'(addr[15:8]);
    if (!m_open[b]) begin
      d = 7;  m_empty++;
    end else if (m_row[b] == r) begin
      d = 3;  m_hit++;
    end else begin
      d = 15; m_conf++;
    end
    m_open[b] = 1;
    m_row[b]  = r;

    in_addr  = addr;
    in_valid = 1;
    in_ready = (hold == 0);
    k = 0; seen = -1; bad = 0;
    while (seen < 0 && k <= 60) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = k;
      end else begin
        if (out_ready !== 1'b0) bad++;
        @(posedge clk); #1;
        k++;
      end
    end
    total++;
    if (seen != d + 2) $display("FAIL %s latency: got %0d want %0d", tag, seen, d + 2);
    else passed++;
    total++;
    if (out_valid3 !== out_valid) $display("FAIL %s sat_dut_valid: got %0b want %0b", tag, out_valid3, out_valid);
    else passed++;
    total++;
    if (bad != 0) $display("FAIL %s ready_gated: got %0d leaks want 0", tag, bad);
    else passed++;

    bad = 0;
    for (int i = 0; i < hold; i++) begin
      if (out_valid !== 1'b1 || out_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      if (i == hold - 1) in_ready = 1;
      @(negedge clk);
    end
    if (hold > 0) begin
      total++;
      if (bad != 0) $display("FAIL %s backpressure: got %0d bad cycles want 0", tag, bad);
      else passed++;
    end
    total++;
    if (out_valid !== 1'b1 || out_ready !== 1'b1)
      $display("FAIL %s handshake: got valid=%0b ready=%0b want 1/1", tag, out_valid, out_ready);
    else passed++;
    @(posedge clk); #1;
    in_valid = 0;
    in_ready = 0;

    total++;
    if (hit_cnt !== 32'(m_hit) || empty_cnt !== 32'(m_empty) || conflict_cnt !== 32'(m_conf))
      $display("FAIL %s counters: got h=%0d e=%0d c=%0d want h=%0d e=%0d c=%0d", tag,
               hit_cnt, empty_cnt, conflict_cnt, m_hit, m_empty, m_conf);
    else passed++;
    e = (m_hit > 3 ? 3 : m_hit) * 16 + (m_empty > 3 ? 3 : m_empty) * 4 + (m_conf > 3 ? 3 : m_conf);
    total++;
    if (int'(hit3) * 16 + int'(empty3) * 4 + int'(conf3) != e)
      $display("FAIL %s sat_counters: got h=%0d e=%0d c=%0d want code %0d", tag, hit3, empty3, conf3, e);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1; rst2 = 1;
    in_valid = 0; in_ready = 0; in_addr = '0;
    in_valid2 = 0; in_ready2 = 0; in_addr2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_ready !== 1'b0 || refresh_busy !== 1'b0)
      $display("FAIL reset_outputs: got %0b%0b%0b want 000", out_valid, out_ready, refresh_busy);
    else passed++;
    total++;
    if (hit_cnt !== 0 || empty_cnt !== 0 || conflict_cnt !== 0)
      $display("FAIL reset_counters: got %0d %0d %0d want 0 0 0", hit_cnt, empty_cnt, conflict_cnt);
    else passed++;
    total++;
    if (refresh_busy2 !== 1'b0 || out_valid2 !== 1'b0)
      $display("FAIL reset_refresh_dut: got busy=%0b valid=%0b want 0 0", refresh_busy2, out_valid2);
    else passed++;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_classify();
    run_request(16'h0100, 0, 0, "first_empty");
    run_request(16'h0120, 1, 0, "row_hit");
    run_request(16'h0220, 2, 0, "conflict");
    run_request(16'h0220, 0, 0, "hit_after_conflict");
    run_request(16'h0100, 0, 0, "reopen_row1");
    run_request(16'h0140, 3, 0, "other_bank_empty");
    run_request(16'h0100, 0, 0, "bank0_still_open");
    run_request(16'h0100, 63, 0, "idle_63_hit");
    run_request(16'h0100, 64, 0, "idle_64_empty");
  endtask

  task automatic test_backpressure();
    run_request(16'h0180, 0, 10, "hold_ready_10");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) run_request(16'h0180, 0, 0, "sat_hits");
    run_request(16'h0280, 0, 0, "sat_conf_a");
    run_request(16'h0380, 0, 0, "sat_conf_b");
    run_request(16'h0280, 0, 0, "sat_conf_c");
    run_request(16'h0380, 0, 0, "sat_conf_d");
  endtask

  task automatic test_random();
    logic [15:0] a;
    int g;
    for (int n = 0; n < 60; n++) begin
      a[15:8] = 8'($urandom_range(0, 2));
      a[7:6]  = 2'($urandom_range(0, 3));
      a[5:0]  = 6'($urandom_range(0, 63));
      g = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(62, 66);
      run_request(a, g, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_midflight();
    in_addr  = 16'h0300;
    in_valid = 1;
    in_ready = 1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1;
    in_valid = 0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || hit_cnt !== 0 || empty_cnt !== 0 || conflict_cnt !== 0)
      $display("FAIL midflight_reset: got valid=%0b h=%0d e=%0d c=%0d want 0", out_valid,
               hit_cnt, empty_cnt, conflict_cnt);
    else passed++;
    rst = 0;
    model_reset();
    run_request(16'h0300, 0, 0, "after_midflight_reset");
  endtask

  task automatic test_refresh();
    int first_busy, busy_n, ov_a, ov_b;
    rst2 = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst2 = 0;
    first_busy = -1; busy_n = 0; ov_a = -1; ov_b = -1;
    for (int e = 1; e <= 75; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        in_addr2 = 16'h0140; in_valid2 = 1; in_ready2 = 1;
      end
      if (e == 11 || e == 71) in_valid2 = 0;
      if (e == 40) begin
        in_addr2 = 16'h0140; in_valid2 = 1;
      end
      @(negedge clk);
      if (refresh_busy2 === 1'b1) begin
        busy_n++;
        if (first_busy < 0) first_busy = e;
      end
      if (out_valid2 === 1'b1 && e < 40 && ov_a < 0) ov_a = e;
      if (out_valid2 === 1'b1 && e >= 40 && ov_b < 0) ov_b = e;
    end
    total++;
    if (ov_a != 10) $display("FAIL refresh_first_latency: got %0d want 10", ov_a);
    else passed++;
    total++;
    if (first_busy != 41) $display("FAIL refresh_wins_start: got %0d want 41", first_busy);
    else passed++;
    total++;
    if (busy_n != 20) $display("FAIL refresh_busy_len: got %0d want 20", busy_n);
    else passed++;
    total++;
    if (ov_b != 70) $display("FAIL refresh_then_request: got %0d want 70", ov_b);
    else passed++;
    total++;
    if (empty2 !== 32'd2 || hit2 !== 32'd0)
      $display("FAIL refresh_closes_banks: got e=%0d h=%0d want e=2 h=0", empty2, hit2);
    else passed++;
  endtask

  task automatic test_refresh_pending();
    int ov, busy_early, busy_mid, bad_hold;
    logic b127, b161;
    rst2 = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst2 = 0;
    ov = -1; busy_early = 0; busy_mid = 0; bad_hold = 0; b127 = 0; b161 = 0;
    for (int e = 1; e <= 165; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        in_addr2 = 16'h0100; in_valid2 = 1; in_ready2 = 0;
      end
      if (e == 125) in_ready2 = 1;
      if (e == 126) begin
        in_valid2 = 0; in_ready2 = 0;
      end
      @(negedge clk);
      if (out_valid2 === 1'b1 && ov < 0) ov = e;
      if (e >= 10 && e <= 124 && (out_valid2 !== 1'b1 || out_ready2 !== 1'b0)) bad_hold++;
      if (refresh_busy2 === 1'b1) begin
        if (e <= 126) busy_early++;
        else if (e <= 160) busy_mid++;
      end
      if (e == 127) b127 = refresh_busy2;
      if (e == 161) b161 = refresh_busy2;
    end
    total++;
    if (ov != 10) $display("FAIL pend_latency: got %0d want 10", ov);
    else passed++;
    total++;
    if (bad_hold != 0) $display("FAIL pend_active_hold: got %0d bad cycles want 0", bad_hold);
    else passed++;
    total++;
    if (busy_early != 0) $display("FAIL pend_no_interrupt: got %0d busy cycles want 0", busy_early);
    else passed++;
    total++;
    if (b127 !== 1'b1) $display("FAIL pend_served_after_hs: got %0b want 1", b127);
    else passed++;
    total++;
    if (busy_mid != 20) $display("FAIL pend_single_flag: got %0d busy cycles want 20", busy_mid);
    else passed++;
    total++;
    if (b161 !== 1'b1) $display("FAIL pend_next_period: got %0b want 1", b161);
    else passed++;
  endtask

  initial begin
    clk = 0;
    passed = 0;
    total = 0;
    test_reset();
    test_classify();
    test_backpressure();
    test_saturation();
    test_random();
    test_reset_midflight();
    test_refresh();
    test_refresh_pending();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
